sha256_msg_schedule: RTL and testbench
======================================

Name: sha256_msg_schedule

Overview:
- Message-schedule stage of the SHA-256 core; sits directly upstream of the round/compression datapath that updates the 32-bit hash registers.
- Accepts one 512-bit block as 16 serial 32-bit words and emits the 64 schedule words W0..W63, one per accepted output beat, with a ready/valid handshake on both sides.
- Holds a 16-entry sliding window of W and computes W16..W63 in place.

Parameters:
- WORD_W, 32, word width; fixed at 32 for SHA-256, not to be overridden.
- ROUNDS, 64, schedule words emitted per block.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  begin new block; sampled only in IDLE
- word_in  in  32  message word from padder/loader, big-endian word order
- word_valid  in  1  word_in valid
- word_ready  out  1  stage accepts word_in this cycle
- w_out  out  32  current schedule word W_t (registered)
- w_idx  out  6  index t of w_out
- w_valid  out  1  w_out/w_idx valid
- w_ready  in  1  downstream round stage consumes w_out this cycle
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse when W63 is consumed

Behaviour:
- Reset (async assert, sync release): state=IDLE, window cleared to 0, t counter=0, w_out=0, w_idx=0, w_valid=0, word_ready=0, busy=0, done=0.
- Output slot: slot_free = !w_valid || w_ready. w_out/w_idx/w_valid update only when slot_free. w_valid is held with stable data until w_ready.
- FSM states and transitions:
  - IDLE: start=1 -> LOAD, t=0. start while busy is ignored.
  - LOAD: word_ready = slot_free. On word_valid && word_ready:
    - shift word_in into window;
    - next cycle w_out=word_in, w_idx=t, w_valid=1; t++.
    - After the 16th accepted word (t=15), go to EXPAND.
  - EXPAND: word_ready=0. When slot_free:
    - W_t = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], mod 2^32, carries discarded;
    - shift W_t into window; present it next cycle with w_idx=t; t++.
    - After issuing t=63, go to DRAIN.
  - DRAIN: wait for w_valid && w_ready with w_idx=63. That cycle: done=1 (registered, visible the following cycle for exactly one cycle), w_valid clears; then go to IDLE.
- Sigma functions:
  - s0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x)
  - s1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
- Latency: the first word appears on w_out 1 cycle after it is accepted. With w_ready tied high and word_valid continuous, W0..W63 occupy 64 consecutive cycles, and done follows 1 cycle after the W63 handshake.
- Throughput: one W per cycle. Back-to-back blocks are allowed: start may be asserted in the cycle after done.
- Stall: while w_ready=0 and w_valid=1, the window, t and FSM freeze. word_valid without word_ready is ignored; the word must be held by the source.
- Reset mid-block: immediately aborts. Partial window is discarded, no done pulse, w_valid drops asynchronously.
- w_idx wraps only via return to IDLE; t never exceeds 63.

Test Plan:
- Reset behaviour: assert reset mid-EXPAND (t=30) -> w_valid, busy, word_ready go 0 at once; after release, start plus a fresh block restarts at w_idx=0.
- "abc" block, w_ready=1: words 61626380, 0x0 x14, 00000018 -> output sequence:
  - W0=61626380, W15=00000018;
  - W16=61626380, W17=000F0000, W18=7DA86405, W19=600003C6;
  - W63=12B1EDEB;
  - done pulses once, one cycle after the W63 handshake;
  - 64 consecutive w_valid cycles.
- Downstream stall: same block, w_ready low for 5 cycles at w_idx=20 -> w_out holds W20 stable, then resumes with W21; sequence identical to the unstalled run.
- Upstream gaps: word_valid toggled 1/0 during LOAD -> only valid words are accepted; W0..W15 equal the inputs in order; EXPAND values unchanged.
- All-zero block -> all W0..W63 = 00000000; done asserted.
- start ignored while busy; back-to-back: start in the cycle after done with a second "abc" block -> identical W sequence, no lost or duplicated beat.

Source files
------------

// File: rtl/sha256_msg_schedule_if.sv
// Handshake bundle between the SHA-256 message loader, the schedule stage and the round stage.
interface sha256_msg_schedule_if #(
  parameter int unsigned WORD_W = 32
);
  // Loader side
  logic              start;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;

  // Round-stage side
  logic [WORD_W-1:0] w_out;
  logic [5:0]        w_idx;
  logic              w_valid;
  logic              w_ready;

  // Status
  logic              busy;
  logic              done;

  // Driver of the schedule stage (loader plus round stage)
  modport master (
    output start,
    output word_in,
    output word_valid,
    input  word_ready,
    input  w_out,
    input  w_idx,
    input  w_valid,
    output w_ready,
    input  busy,
    input  done
  );

  // The schedule stage itself
  modport slave (
    input  start,
    input  word_in,
    input  word_valid,
    output word_ready,
    output w_out,
    output w_idx,
    output w_valid,
    input  w_ready,
    output busy,
    output done
  );
endinterface

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 message words, then expands W16..W63 in a 16-deep
// sliding window. Every W_t is presented through a single registered ready/valid slot.
module sha256_msg_schedule #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROUNDS = 64
) (
  input logic                  clk,
  input logic                  reset,
  sha256_msg_schedule_if.slave sched_io
);

  localparam int              WinDepth    = 16;
  localparam int              IdxW        = 6;
  localparam logic [IdxW-1:0] LastLoadIdx = IdxW'(WinDepth - 1);
  localparam logic [IdxW-1:0] LastIdx     = IdxW'(ROUNDS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StExpand,
    StDrain
  } state_e;

  state_e            state_q, state_d;

  // win_q[15] holds W[t-1], win_q[0] holds W[t-16]
  logic [WORD_W-1:0] win_q [WinDepth];
  logic [WORD_W-1:0] win_d [WinDepth];
  logic [IdxW-1:0]   t_q, t_d;
  logic [WORD_W-1:0] w_out_q, w_out_d;
  logic [IdxW-1:0]   w_idx_q, w_idx_d;
  logic              w_valid_q, w_valid_d;
  logic              done_q, done_d;

  logic              slot_free;
  logic              word_ready;
  logic              load_fire;
  logic              expand_fire;
  logic              drain_fire;
  logic [WORD_W-1:0] w_new;

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // Output slot can take a new word when empty or being consumed this cycle
  assign slot_free = !w_valid_q || sched_io.w_ready;

  // W_t = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], carries out of bit 31 dropped
  assign w_new = sigma1(win_q[14]) + win_q[9] + sigma0(win_q[1]) + win_q[0];

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (sched_io.start) state_d = StLoad;
      StLoad:   if (load_fire && (t_q == LastLoadIdx)) state_d = StExpand;
      StExpand: if (expand_fire && (t_q == LastIdx)) state_d = StDrain;
      StDrain:  if (drain_fire) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs: handshake strobes that advance the datapath
  always_comb begin
    word_ready  = 1'b0;
    load_fire   = 1'b0;
    expand_fire = 1'b0;
    drain_fire  = 1'b0;
    unique case (state_q)
      StLoad: begin
        word_ready = slot_free;
        load_fire  = slot_free && sched_io.word_valid;
      end
      StExpand: expand_fire = slot_free;
      StDrain:  drain_fire  = w_valid_q && sched_io.w_ready && (w_idx_q == LastIdx);
      default: ;
    endcase
  end

  // Datapath next state: window shift, t counter, output slot and done pulse
  always_comb begin
    win_d     = win_q;
    t_d       = t_q;
    w_out_d   = w_out_q;
    w_idx_d   = w_idx_q;
    w_valid_d = w_valid_q;
    done_d    = 1'b0;

    if ((state_q == StIdle) && sched_io.start) begin
      t_d = '0;
    end

    if (slot_free) begin
      w_valid_d = 1'b0;
    end

    if (load_fire || expand_fire) begin
      for (int i = 0; i < WinDepth - 1; i++) begin
        win_d[i] = win_q[i+1];
      end
      win_d[WinDepth-1] = load_fire ? sched_io.word_in : w_new;
      w_out_d           = load_fire ? sched_io.word_in : w_new;
      w_idx_d           = t_q;
      w_valid_d         = 1'b1;
      // t parks at the last index; it is cleared by the next start
      if (t_q != LastIdx) begin
        t_d = t_q + IdxW'(1);
      end
    end

    if (drain_fire) begin
      done_d = 1'b1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WinDepth; i++) begin
        win_q[i] <= '0;
      end
      t_q       <= '0;
      w_out_q   <= '0;
      w_idx_q   <= '0;
      w_valid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      win_q     <= win_d;
      t_q       <= t_d;
      w_out_q   <= w_out_d;
      w_idx_q   <= w_idx_d;
      w_valid_q <= w_valid_d;
      done_q    <= done_d;
    end
  end

  assign sched_io.word_ready = word_ready;
  assign sched_io.w_out      = w_out_q;
  assign sched_io.w_idx      = w_idx_q;
  assign sched_io.w_valid    = w_valid_q;
  assign sched_io.busy       = (state_q != StIdle);
  assign sched_io.done       = done_q;

  // A presented word must stay put until the round stage takes it
  a_stall_stable: assert property (@(posedge clk) disable iff (reset)
    (w_valid_q && !sched_io.w_ready) |=> (w_valid_q && $stable(w_out_q) && $stable(w_idx_q)));

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Bench for sha256_msg_schedule: scoreboard of expected (index, word) beats per block.
module tb_sha256_msg_schedule;

  logic clk;
  logic reset;

  sha256_msg_schedule_if #(.WORD_W(32)) bus ();

  sha256_msg_schedule #(
    .WORD_W(32),
    .ROUNDS(64)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sched_io(bus)
  );

  int checks = 0;
  int errors = 0;

  logic [37:0] exp_q[$];
  logic [31:0] blk     [16];
  logic [31:0] mw      [64];
  logic [31:0] got     [64];
  logic [31:0] abc_ref [64];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic load_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
  endtask

  task automatic load_zero();
    for (int i = 0; i < 16; i++) blk[i] = 32'h0;
  endtask

  // Reference schedule from the full 64-entry array, queued in emission order
  task automatic push_expected();
    for (int t = 0; t < 64; t++) begin
      if (t < 16) mw[t] = blk[t];
      else mw[t] = ss1(mw[t-2]) + mw[t-7] + ss0(mw[t-15]) + mw[t-16];
      exp_q.push_back({6'(t), mw[t]});
    end
  endtask

  // Runs one block from IDLE; returns at the negedge of the cycle after done
  task automatic run_block(input int stall_at, input int stall_len, input bit gappy,
                           input bit poke_start, output int n_done, output int n_valid,
                           output int first_v, output int last_v);
    int sent;
    int cyc;
    int stall_left;
    int hs_last;
    int done_cyc;
    logic [37:0] e;
    sent = 0; cyc = 0; stall_left = stall_len; hs_last = -1; done_cyc = -1;
    n_done = 0; n_valid = 0; first_v = -1; last_v = -1;
    for (int i = 0; i < 64; i++) got[i] = 32'hxxxxxxxx;
    push_expected();
    bus.start = 1'b1; bus.word_valid = 1'b0; bus.w_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < 1000) begin
      if (hs_last >= 0 && cyc > hs_last + 1) break;
      bus.start = poke_start && (hs_last < 0);
      if (sent < 16 && (!gappy || (cyc % 2) == 0)) begin
        bus.word_valid = 1'b1;
        bus.word_in    = blk[sent];
      end else begin
        bus.word_valid = 1'b0;
        bus.word_in    = $urandom;
      end
      if (stall_at >= 0 && bus.w_valid && int'(bus.w_idx) == stall_at && stall_left > 0) begin
        bus.w_ready = 1'b0;
        stall_left--;
        checks++;
        if ({bus.w_idx, bus.w_out} !== exp_q[0]) begin
          errors++;
          $display("FAIL stall_hold got idx=%0d w=%h want %h", bus.w_idx, bus.w_out, exp_q[0]);
        end
      end else begin
        bus.w_ready = 1'b1;
      end
      #1;
      if (bus.w_valid) begin
        n_valid++;
        if (first_v < 0) first_v = cyc;
        last_v = cyc;
      end
      if (bus.done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (bus.word_valid && bus.word_ready) sent++;
      if (bus.w_valid && bus.w_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra got idx=%0d w=%h want no beat", bus.w_idx, bus.w_out);
        end else begin
          e = exp_q.pop_front();
          if ({bus.w_idx, bus.w_out} !== e) begin
            errors++;
            $display("FAIL sb_beat got idx=%0d w=%h want idx=%0d w=%h",
                     bus.w_idx, bus.w_out, e[37:32], e[31:0]);
          end
        end
        got[bus.w_idx] = bus.w_out;
        if (bus.w_idx == 6'd63) hs_last = cyc;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0; bus.word_valid = 1'b0; bus.w_ready = 1'b1;
    checks++;
    if (hs_last < 0) begin
      errors++;
      $display("FAIL block_timeout got no W63 handshake want one within 1000 cycles");
    end
    checks++;
    if (n_done != 1 || done_cyc != hs_last + 1) begin
      errors++;
      $display("FAIL done_pulse got count=%0d at cyc=%0d want 1 at cyc=%0d",
               n_done, done_cyc, hs_last + 1);
    end
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL done_width got done=%b want 0 one cycle later", bus.done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d beats missing want 0", exp_q.size());
      exp_q.delete();
    end
    if (stall_at >= 0) begin
      checks++;
      if (stall_left != 0) begin
        errors++;
        $display("FAIL stall_taken got %0d stall cycles left want 0", stall_left);
      end
    end
  endtask

  task automatic test_reset();
    int sent;
    int cyc;
    int nd, nv, fv, lv;
    reset = 1'b1;
    bus.start = 1'b0; bus.word_valid = 1'b0; bus.word_in = '0; bus.w_ready = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.w_valid, bus.busy, bus.word_ready, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got valid/busy/ready/done=%b want 0000",
               {bus.w_valid, bus.busy, bus.word_ready, bus.done});
    end
    checks++;
    if (bus.w_out !== 32'h0 || bus.w_idx !== 6'h0) begin
      errors++;
      $display("FAIL reset_out got w=%h idx=%0d want 0 0", bus.w_out, bus.w_idx);
    end
    reset = 1'b0;
    @(negedge clk);

    // Partial block up to W30, then abort with reset
    load_abc();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    sent = 0; cyc = 0;
    while (!(bus.w_valid && bus.w_idx == 6'd30) && cyc < 200) begin
      bus.word_valid = (sent < 16);
      bus.word_in    = (sent < 16) ? blk[sent] : 32'h0;
      #1;
      if (bus.word_valid && bus.word_ready) sent++;
      @(negedge clk);
      cyc++;
    end
    bus.word_valid = 1'b0;
    checks++;
    if (!(bus.w_valid && bus.w_idx == 6'd30 && bus.busy)) begin
      errors++;
      $display("FAIL reach_w30 got valid=%b idx=%0d want 1 30", bus.w_valid, bus.w_idx);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({bus.w_valid, bus.busy, bus.word_ready, bus.done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got valid/busy/ready/done=%b want 0000",
               {bus.w_valid, bus.busy, bus.word_ready, bus.done});
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_block(-1, 0, 1'b0, 1'b0, nd, nv, fv, lv);
    checks++;
    if (got[0] !== 32'h61626380) begin
      errors++;
      $display("FAIL restart_w0 got %h want 61626380", got[0]);
    end
  endtask

  task automatic test_abc();
    int nd, nv, fv, lv;
    logic [31:0] ref_w [7];
    int ref_i [7];
    ref_i[0] = 0;  ref_w[0] = 32'h61626380;
    ref_i[1] = 15; ref_w[1] = 32'h00000018;
    ref_i[2] = 16; ref_w[2] = 32'h61626380;
    ref_i[3] = 17; ref_w[3] = 32'h000F0000;
    ref_i[4] = 18; ref_w[4] = 32'h7DA86405;
    ref_i[5] = 19; ref_w[5] = 32'h600003C6;
    ref_i[6] = 63; ref_w[6] = 32'h12B1EDEB;
    load_abc();
    run_block(-1, 0, 1'b0, 1'b0, nd, nv, fv, lv);
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (got[ref_i[k]] !== ref_w[k]) begin
        errors++;
        $display("FAIL abc_w%0d got %h want %h", ref_i[k], got[ref_i[k]], ref_w[k]);
      end
    end
    checks++;
    if (nv != 64 || lv - fv != 63) begin
      errors++;
      $display("FAIL abc_consecutive got %0d valid over span %0d want 64 over 63", nv, lv - fv);
    end
    for (int i = 0; i < 64; i++) abc_ref[i] = got[i];
  endtask

  task automatic test_stall();
    int nd, nv, fv, lv, bad;
    load_abc();
    run_block(20, 5, 1'b0, 1'b0, nd, nv, fv, lv);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== abc_ref[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_seq got %0d words differing want 0", bad);
    end
  endtask

  task automatic test_gaps();
    int nd, nv, fv, lv, bad;
    load_abc();
    run_block(-1, 0, 1'b1, 1'b0, nd, nv, fv, lv);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== abc_ref[i]) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gaps_seq got %0d words differing want 0", bad);
    end
  endtask

  task automatic test_zero();
    int nd, nv, fv, lv, bad;
    load_zero();
    run_block(-1, 0, 1'b0, 1'b0, nd, nv, fv, lv);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== 32'h0) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL zero_seq got %0d nonzero words want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    int nd, nv, fv, lv, bad;
    load_abc();
    run_block(-1, 0, 1'b0, 1'b1, nd, nv, fv, lv);
    checks++;
    if (nv != 64) begin
      errors++;
      $display("FAIL busy_start got %0d valid beats want 64", nv);
    end
    run_block(-1, 0, 1'b0, 1'b0, nd, nv, fv, lv);
    bad = 0;
    for (int i = 0; i < 64; i++) if (got[i] !== abc_ref[i]) bad++;
    checks++;
    if (bad != 0 || nv != 64) begin
      errors++;
      $display("FAIL b2b_seq got %0d differing, %0d beats want 0, 64", bad, nv);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_stall();
    test_gaps();
    test_zero();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
